// File: rtl/led_latch_bank.sv
// led_latch_bank: WIDTH-bit LED/hit latch (register, sticky OR, timed hold, freeze); LED_in/load to LED_out in 1 clk, no backpressure.
// Optional blinking of expiring timed bits is built only when LED_LATCH_BLINK_EN is defined.
module led_latch_bank #(
  parameter int WIDTH        = 8,
  parameter int HOLD_W       = 16,
  parameter int BLINK_THRESH = 8,
  parameter int BLINK_DIV_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  LED_in,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  clr,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic [WIDTH-1:0]  LED_out,
  output logic [WIDTH-1:0]  expired
);

  localparam logic [1:0] MODE_REG    = 2'b00;
  localparam logic [1:0] MODE_STICKY = 2'b01;
  localparam logic [1:0] MODE_TIMED  = 2'b10;
  localparam logic [HOLD_W-1:0] TIMER_ONE = HOLD_W'(1);

  logic [WIDTH-1:0]  r_state;
  logic [WIDTH-1:0]  r_expired;
  logic [HOLD_W-1:0] r_timer [WIDTH];
  logic              w_timed_load;

  assign w_timed_load = load && (hold_cycles != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= '0;
      r_expired <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_timer[i] <= '0;
      end
    end else begin
      r_expired <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (clr[i]) begin
          r_state[i] <= 1'b0;
          r_timer[i] <= '0;
        end else if (mode == MODE_TIMED) begin
          if (w_timed_load && LED_in[i]) begin
            r_state[i] <= 1'b1;
            r_timer[i] <= hold_cycles;
          end else if (r_state[i] && (r_timer[i] != '0)) begin
            // Bits lit with a zero timer (carried in from another mode) stay lit.
            if (r_timer[i] == TIMER_ONE) begin
              r_state[i]   <= 1'b0;
              r_timer[i]   <= '0;
              r_expired[i] <= 1'b1;
            end else begin
              r_timer[i] <= r_timer[i] - TIMER_ONE;
            end
          end
        end else begin
          // Timers only run in timed mode; any other mode drops them to zero.
          r_timer[i] <= '0;
          if (load && (mode == MODE_REG)) begin
            r_state[i] <= LED_in[i];
          end else if (load && (mode == MODE_STICKY)) begin
            r_state[i] <= r_state[i] | LED_in[i];
          end
        end
      end
    end
  end

  assign expired = r_expired;

`ifdef LED_LATCH_BLINK_EN
  logic [BLINK_DIV_W-1:0] r_blink_cnt;
  logic                   r_phase;
  logic [WIDTH-1:0]       w_led_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
      if (&r_blink_cnt) begin
        r_phase <= ~r_phase;
      end
    end
  end

  // Static lit bits (timer zero) are not counting down, so they stay steady.
  always_comb begin
    w_led_out = r_state;
    if (mode == MODE_TIMED) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_timer[i] != '0) && (r_timer[i] <= HOLD_W'(BLINK_THRESH))) begin
          w_led_out[i] = r_state[i] & r_phase;
        end
      end
    end
  end

  assign LED_out = w_led_out;
`else
  logic w_unused_blink_cfg;
  assign w_unused_blink_cfg = (BLINK_THRESH > 0) ^ (BLINK_DIV_W > 0);
  assign LED_out = r_state;
`endif

endmodule

// File: tb/tb_led_latch_bank.sv
// Directed self-checking bench for led_latch_bank (default build, blink disabled).
module tb_led_latch_bank;

  logic        clk;
  logic        rst;
  logic [7:0]  LED_in;
  logic        load;
  logic [1:0]  mode;
  logic [7:0]  clr;
  logic [15:0] hold_cycles;
  logic [7:0]  LED_out;
  logic [7:0]  expired;

  int n_checks = 0;
  int n_fail   = 0;

  led_latch_bank #(
    .WIDTH(8), .HOLD_W(16), .BLINK_THRESH(8), .BLINK_DIV_W(4)
  ) dut (
    .clk(clk), .rst(rst), .LED_in(LED_in), .load(load), .mode(mode),
    .clr(clr), .hold_cycles(hold_cycles), .LED_out(LED_out), .expired(expired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_led [5];
  logic [7:0] exp_exp [5];

  initial begin
    rst = 1'b0; LED_in = '0; load = 1'b0; mode = 2'b00; clr = '0; hold_cycles = '0;
    #2;
    check("reset_led", LED_out, 8'h00);
    check("reset_exp", expired, 8'h00);
    tick();
    rst = 1'b1;
    tick();

    // Plain register mode.
    mode = 2'b00; LED_in = 8'hA5; load = 1'b1;
    #1 check("reg_pre_edge", LED_out, 8'h00);
    tick();
    check("reg_load", LED_out, 8'hA5);
    load = 1'b0; LED_in = 8'hFF;
    tick();
    check("reg_hold1", LED_out, 8'hA5);
    tick();
    check("reg_hold2", LED_out, 8'hA5);
    LED_in = 8'hFF; load = 1'b1; clr = 8'h0F;
    tick();
    check("reg_clr_beats_load", LED_out, 8'hF0);
    LED_in = 8'h00; clr = 8'h00;
    tick();
    check("reg_load_zero", LED_out, 8'h00);

    // Sticky OR mode.
    mode = 2'b01; load = 1'b1; LED_in = 8'h01;
    tick();
    check("sticky_01", LED_out, 8'h01);
    LED_in = 8'h80;
    tick();
    check("sticky_81", LED_out, 8'h81);
    load = 1'b0; LED_in = 8'h00; clr = 8'h01;
    tick();
    check("sticky_clr", LED_out, 8'h80);
    clr = 8'hFF;
    tick();
    check("sticky_clr_all", LED_out, 8'h00);
    clr = 8'h00;

    // Timed hold, hold_cycles=3: lit for exactly 3 cycles, then one expired pulse.
    exp_led = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
    exp_exp = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
    mode = 2'b10; hold_cycles = 16'd3; LED_in = 8'h04; load = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      load = 1'b0; LED_in = 8'h00;
      check($sformatf("timed3_led_%0d", k), LED_out, exp_led[k]);
      check($sformatf("timed3_exp_%0d", k), expired, exp_exp[k]);
    end

    // Retrigger after 2 cycles, then clr on the timeout edge.
    hold_cycles = 16'd4; LED_in = 8'h04; load = 1'b1;
    tick();
    load = 1'b0; LED_in = 8'h00;
    tick();
    check("retrig_first_lit", LED_out, 8'h04);
    LED_in = 8'h04; load = 1'b1;
    tick();
    load = 1'b0; LED_in = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("retrig_lit_%0d", k), LED_out, 8'h04);
      check($sformatf("retrig_noexp_%0d", k), expired, 8'h00);
    end
    clr = 8'h04;
    tick();
    clr = 8'h00;
    check("retrig_clr_led", LED_out, 8'h00);
    check("retrig_clr_noexp", expired, 8'h00);
    tick();
    check("retrig_clr_noexp_late", expired, 8'h00);

    // hold_cycles==0 makes load a no-op in timed mode.
    hold_cycles = 16'd0; LED_in = 8'hFF; load = 1'b1;
    tick();
    check("timed_hold0_ignored", LED_out, 8'h00);

    // Leave timed mode mid-countdown: freeze keeps the bit, timers zeroed.
    hold_cycles = 16'd5; LED_in = 8'h10; load = 1'b1;
    tick();
    load = 1'b0; LED_in = 8'h00;
    tick();
    mode = 2'b11;
    tick();
    check("freeze_keep", LED_out, 8'h10);
    LED_in = 8'hFF; load = 1'b1;
    tick();
    check("freeze_load_ignored", LED_out, 8'h10);
    load = 1'b0; LED_in = 8'h00; mode = 2'b10;
    for (int k = 0; k < 6; k++) tick();
    check("reenter_timed_static", LED_out, 8'h10);
    check("reenter_timed_noexp", expired, 8'h00);
    clr = 8'h10;
    tick();
    clr = 8'h00;
    check("reenter_timed_clr", LED_out, 8'h00);

    // Asynchronous reset mid-countdown (timer at 5).
    hold_cycles = 16'd8; LED_in = 8'h01; load = 1'b1;
    tick();
    load = 1'b0; LED_in = 8'h00;
    tick(); tick(); tick();
    check("arst_pre_lit", LED_out, 8'h01);
    #2 rst = 1'b0;
    #1;
    check("arst_led_immediate", LED_out, 8'h00);
    check("arst_exp_immediate", expired, 8'h00);
    #2 rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("arst_after_exp_%0d", k), expired, 8'h00);
    end
    check("arst_after_led", LED_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
